// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder driving one external full adder,
// LSB first, one bit per clock, with registered sum and final carry.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             fa_x,
  output logic             fa_y,
  output logic             fa_c_in,
  input  logic             fa_sum,
  input  logic             fa_c_out
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d, sum_q, sum_d;
  logic             carry_q, carry_d, c_out_q, c_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run;

  assign run     = state_q == RUN;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign sum     = sum_q;
  assign c_out   = c_out_q;
  assign fa_x    = run & a_sh_q[0];
  assign fa_y    = run & b_sh_q[0];
  assign fa_c_in = run & carry_q;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    c_out_d  = c_out_q;
    cnt_d    = cnt_q;
    if (state_q == IDLE && start) begin
      state_d = RUN;
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = c_in;
      cnt_d   = '0;
    end else if (run) begin
      sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
      carry_d  = fa_c_out;
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      // last bit: publish the completed result on the same edge it is captured
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = DONE;
        sum_d   = sum_sh_d;
        c_out_d = fa_c_out;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      c_out_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      c_out_q  <= c_out_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=13,
// each instance wrapped around a behavioural full adder.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start1 = 1'b0, c1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0, sum1;
  logic       busy1, done1, cout1, fx1, fy1, fc1, fs1, fco1;

  logic        start2 = 1'b0, c2 = 1'b0;
  logic [12:0] a2 = '0, b2 = '0, sum2;
  logic        busy2, done2, cout2, fx2, fy2, fc2, fs2, fco2;

  assign fs1  = fx1 ^ fy1 ^ fc1;
  assign fco1 = (fx1 & fy1) | (fx1 & fc1) | (fy1 & fc1);
  assign fs2  = fx2 ^ fy2 ^ fc2;
  assign fco2 = (fx2 & fy2) | (fx2 & fc2) | (fy2 & fc2);

  serial_adder_ctrl #(.WIDTH(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c_in(c1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1),
    .fa_x(fx1), .fa_y(fy1), .fa_c_in(fc1), .fa_sum(fs1), .fa_c_out(fco1)
  );

  serial_adder_ctrl #(.WIDTH(13)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .c_in(c2),
    .busy(busy2), .done(done2), .sum(sum2), .c_out(cout2),
    .fa_x(fx2), .fa_y(fy2), .fa_c_in(fc2), .fa_sum(fs2), .fa_c_out(fco2)
  );

  int errors = 0, checks = 0, cyc = 0;
  int done_cnt1 = 0, done_cnt2 = 0, last1 = -1, last2 = -1;
  bit held1 = 0, held2 = 0;
  logic [8:0]  q1[$];
  logic [13:0] q2[$];
  logic [8:0]  prev = '0;
  logic [7:0]  trace;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) chk("w8_unexpected_done", 1, 0);
      else chk("w8_result", {cout1, sum1}, q1.pop_front());
      if (held1 && last1 >= 0) chk("w8_spacing", cyc - last1, 10);
      last1 = cyc;
      done_cnt1++;
    end
    if (done2) begin
      if (q2.size() == 0) chk("w13_unexpected_done", 1, 0);
      else chk("w13_result", {cout2, sum2}, q2.pop_front());
      if (held2 && last2 >= 0) chk("w13_spacing", cyc - last2, 15);
      last2 = cyc;
      done_cnt2++;
    end
  end

  task automatic issue(input logic [7:0] aa, input logic [7:0] bb, input logic cc, input bit push);
    @(posedge clk); #1;
    start1 = 1'b1; a1 = aa; b1 = bb; c1 = cc;
    if (push) q1.push_back(9'(aa) + 9'(bb) + 9'(cc));
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input logic cc);
    logic [8:0] exp;
    int n, bc;
    exp = 9'(aa) + 9'(bb) + 9'(cc);
    issue(aa, bb, cc, 1);
    trace = '0;
    trace[0] = fc1;
    bc = int'(busy1);
    for (n = 1; n < 40; n++) begin
      @(posedge clk); #1;
      bc += int'(busy1);
      if (done1) break;
      if (n < 8) trace[n] = fc1;
      if (n == 4) chk("hold_prev", {cout1, sum1}, prev);
    end
    chk("done_latency", n, 8);
    chk("busy_cycles", bc, 9);
    @(posedge clk); #1;
    chk("idle_after_done", {busy1, done1}, 2'b00);
    chk("result_held", {cout1, sum1}, exp);
    prev = exp;
  endtask

  task automatic wait_idle1();
    int k = 0;
    while (busy1 && k < 100) begin @(posedge clk); #1; k++; end
    if (k >= 100) chk("w8_idle_timeout", 1, 0);
  endtask

  task automatic wait_idle2();
    int k = 0;
    while (busy2 && k < 100) begin @(posedge clk); #1; k++; end
    if (k >= 100) chk("w13_idle_timeout", 1, 0);
  endtask

  initial begin
    int dc0;
    #2;
    chk("reset_state", {busy1, done1, cout1, sum1, fx1, fy1, fc1}, '0);
    chk("reset_state_w13", {busy2, done2, cout2, sum2}, '0);
    @(negedge clk); rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    chk("carry_trace", trace, 8'hFE);
    run_op(8'hFF, 8'hFF, 1'b1);
    run_op(8'h00, 8'h00, 1'b0);

    dc0 = done_cnt1;
    issue(8'h12, 8'h34, 1'b0, 1);
    repeat (2) @(posedge clk);
    #1; start1 = 1'b1; a1 = 8'hAA; b1 = 8'h55;
    @(posedge clk); #1; start1 = 1'b0;
    wait_idle1();
    repeat (12) @(posedge clk);
    #1;
    chk("single_done", done_cnt1 - dc0, 1);
    chk("ignored_start_result", {cout1, sum1}, 9'h046);

    issue(8'h80, 8'h80, 1'b0, 0);
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    chk("reset_abort", {busy1, done1, cout1, sum1, fx1, fy1, fc1}, '0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    prev = '0;
    chk("no_done_in_abort", done_cnt1 - dc0, 1);
    run_op(8'h80, 8'h80, 1'b0);

    held1 = 1; held2 = 1; last1 = -1; last2 = -1;
    fork
      begin
        start1 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
          wait_idle1();
          a1 = 8'($urandom); b1 = 8'($urandom); c1 = 1'($urandom);
          q1.push_back(9'(a1) + 9'(b1) + 9'(c1));
          @(posedge clk); #1;
        end
        start1 = 1'b0;
        wait_idle1();
      end
      begin
        start2 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
          wait_idle2();
          a2 = 13'($urandom); b2 = 13'($urandom); c2 = 1'($urandom);
          q2.push_back(14'(a2) + 14'(b2) + 14'(c2));
          @(posedge clk); #1;
        end
        start2 = 1'b0;
        wait_idle2();
      end
    join
    repeat (3) @(posedge clk);
    held1 = 0; held2 = 0;
    chk("w8_queue_empty", q1.size(), 0);
    chk("w13_queue_empty", q2.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that computes a WIDTH-bit sum one bit per clock through a single external 1-bit full adder. The block latches two operands and a carry-in on a start pulse. Each cycle it presents one LSB-first bit pair plus the stored carry to the full adder's x/y/c_in inputs, then captures the adder's sum/c_out. It sits directly around the combinational full adder: upstream it feeds the adder's inputs, and downstream it consumes and registers the adder's outputs.

## Interface
- WIDTH, default 8: operand/result width in bits; legal range 2..32.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  WIDTH  first operand; sampled on the accepting edge.
- b  input  WIDTH  second operand; sampled on the accepting edge.
- c_in  input  1  initial carry; sampled on the accepting edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result; holds until the next completion.
- c_out  output  1  registered final carry; holds until the next completion.
- fa_x  output  1  to full adder x.
- fa_y  output  1  to full adder y.
- fa_c_in  output  1  to full adder c_in.
- fa_sum  input  1  from full adder sum.
- fa_c_out  input  1  from full adder c_out.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when start=1. On that edge: a_sh←a, b_sh←b, carry←c_in, cnt←0.
- RUN drives fa_x=a_sh[0], fa_y=b_sh[0] and fa_c_in=carry, combinationally from registers.
- Each RUN edge:
  - sum_sh←{fa_sum, sum_sh[WIDTH-1:1]}
  - carry←fa_c_out
  - a_sh and b_sh shift right by 1, zero-fill
  - cnt←cnt+1
- RUN → DONE on the edge where cnt==WIDTH-1. On that same edge: sum←{fa_sum, sum_sh[WIDTH-1:1]}, c_out←fa_c_out.
- DONE → IDLE unconditionally on the next edge. done=1 only in DONE.
- fa_x, fa_y and fa_c_in are 0 in IDLE and DONE.
- cnt width is $clog2(WIDTH). The counter never wraps because the exit occurs at WIDTH-1.
- The result is exactly {c_out,sum} = a+b+c_in, modulo 2^(WIDTH+1).

## Timing
- Reset (rst_n=0, any time) forces:
  - state=IDLE
  - busy=0, done=0
  - sum=0, c_out=0
  - fa_x=fa_y=fa_c_in=0
  - all internal registers 0
- Reset is asynchronous on assertion. Deassertion is synchronous to clk, with the first sample on the following rising edge.
- Reset during RUN aborts the operation. No done pulse is produced, and sum/c_out read 0.
- Accepting edge is E0. Bit i is presented between E_i and E_(i+1) and captured on E_(i+1).
- done is high for the cycle following E_WIDTH, which is WIDTH cycles after acceptance. Busy spans WIDTH+1 cycles.
- start while busy=1 is ignored; no queuing occurs.
- If start is held high continuously, a new operation is accepted on the first edge after returning to IDLE. The throughput is one result per WIDTH+2 cycles.
- Changes on a, b and c_in after E0 have no effect on the operation in progress.
- sum and c_out change only on the completion edge. They are stable while done=1 and afterwards.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, c_in=0, start pulse → done exactly 8 cycles after acceptance, sum=0x96, c_out=0, busy high 9 cycles.
- a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1. fa_c_in traces 0,1,1,1,1,1,1,1 across the bit cycles.
- a=0xFF, b=0xFF, c_in=1 → sum=0xFF, c_out=1. Then a=0x00, b=0x00, c_in=0 → sum=0x00, c_out=0, and the previous result held until that completion.
- Pulse start with a=0x12, b=0x34; pulse start again at cycle 3 with a=0xAA, b=0x55 → the second start is ignored, and the result is sum=0x46, c_out=0 with a single done pulse.
- Start a=0x80, b=0x80, then assert rst_n=0 at cycle 4 → outputs 0 immediately with no done. After release, start a=0x80, b=0x80 → sum=0x00, c_out=1.
- Random a, b, c_in over 1000 operations with WIDTH=8 and WIDTH=13, start held high → every done pulse matches a+b+c_in, and pulses are spaced WIDTH+2 cycles apart.
